// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } mst_state_e;

endpackage

// File: rtl/axi_lite_wait_timer.sv
// Channel-wait counter for the AXI4-Lite master; flags expiry on the cycle the
// wait would reach TIMEOUT_CYCLES so the master can abort on that edge.
module axi_lite_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A progressing channel (clear) always wins over expiry in the same cycle.
    assign expired_o = en_i && !clear_i && (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one command in flight, every BRESP/RRESP returned.
// Optional channel-wait abort enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("axi4_lite_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    mst_state_e          state_q;
    logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                aw_done_q, w_done_q;
    logic [ADDR_W-1:0]   awaddr_q, araddr_q;
    logic [DATA_W-1:0]   wdata_q, rsp_rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                rsp_valid_q;
    logic [1:0]          rsp_resp_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_req_done;

    assign aw_hs       = awvalid_q && AWREADY;
    assign w_hs        = wvalid_q && WREADY;
    assign b_hs        = bready_q && BVALID;
    assign ar_hs       = arvalid_q && ARREADY;
    assign r_hs        = rready_q && RVALID;
    assign wr_req_done = (state_q == ST_WR_REQ) && (aw_done_q || aw_hs) && (w_done_q || w_hs);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    logic waiting, tmr_clear, tmr_expired, rsp_timeout_q;

    assign waiting   = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                       (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    // Any state-advancing handshake restarts the wait for the next channel.
    assign tmr_clear = !waiting || wr_req_done || b_hs || ar_hs || r_hs;

    axi_lite_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (ACLK),
        .rst_i    (ARESET),
        .clear_i  (tmr_clear),
        .en_i     (waiting),
        .expired_o(tmr_expired)
    );

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE) && !ARESET;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (wr_req_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= BRESP;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= RRESP;
                        rsp_rdata_q <= RDATA;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
            // Debug abort: deliberately drops VALIDs before their handshake.
            if (tmr_expired) begin
                awvalid_q     <= 1'b0;
                wvalid_q      <= 1'b0;
                bready_q      <= 1'b0;
                arvalid_q     <= 1'b0;
                rready_q      <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_resp_q    <= RESP_SLVERR;
                rsp_rdata_q   <= '0;
                rsp_timeout_q <= 1'b1;
                state_q       <= ST_RSP;
            end
`endif
        end
    end

    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a behavioural 8x32 register-bank slave.
`timescale 1ns/1ps
module tb_axi4_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    // Register-bank slave model with per-channel ready delays.
    logic [31:0] mem [8];
    int          aw_wait, w_wait, ar_wait;
    logic        ar_stuck, r_hold;
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got, ar_got;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
    logic [3:0]  w_strb_l;

    assign AWREADY = AWVALID && (aw_cnt >= aw_wait) && !aw_got;
    assign WREADY  = WVALID && (w_cnt >= w_wait) && !w_got;
    assign ARREADY = ARVALID && (ar_cnt >= ar_wait) && !ar_stuck && !RVALID && !ar_got;

    always @(posedge ACLK) begin : slave
        logic        aw_now, w_now, ar_now;
        logic [31:0] a, d, ra;
        logic [3:0]  s;
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            BVALID <= 1'b0; RVALID <= 1'b0;
            BRESP <= 2'b00; RRESP <= 2'b00; RDATA <= 32'h0;
            for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            aw_now = aw_got || AWREADY;
            w_now  = w_got || WREADY;
            a = aw_got ? aw_addr_l : AWADDR;
            d = w_got ? w_data_l : WDATA;
            s = w_got ? w_strb_l : WSTRB;
            if (AWREADY) begin aw_got <= 1'b1; aw_addr_l <= AWADDR; end
            if (WREADY) begin w_got <= 1'b1; w_data_l <= WDATA; w_strb_l <= WSTRB; end
            if (aw_now && w_now && !BVALID) begin
                if (a < 32'h20) begin
                    for (int i = 0; i < 4; i++)
                        if (s[i]) mem[a[4:2]][8*i +: 8] <= d[8*i +: 8];
                    BRESP <= 2'b00;
                end else begin
                    BRESP <= 2'b10;
                end
                BVALID <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            ar_now = ar_got || ARREADY;
            ra = ar_got ? ar_addr_l : ARADDR;
            if (ARREADY) begin ar_got <= 1'b1; ar_addr_l <= ARADDR; end
            if (ar_now && !r_hold && !RVALID) begin
                RVALID <= 1'b1;
                RDATA  <= (ra < 32'h20) ? mem[ra[4:2]] : 32'h0;
                RRESP  <= (ra < 32'h20) ? 2'b00 : 2'b10;
                ar_got <= 1'b0;
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
        end
    end

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output bit ok);
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge ACLK);
        end
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output bit ok, output logic [31:0] rd, output logic [1:0] rr,
                           output logic to);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge ACLK);
        end
        rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        n_checks++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, cmd_ready} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, cmd_ready}); end
        n_checks++; if ({AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp} !== 134'h0) begin
            n_fail++; $display("FAIL reset_payload: AWADDR=%h ARADDR=%h WDATA=%h WSTRB=%h rdata=%h resp=%b want all 0", AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp); end
        ARESET = 1'b0;
        @(negedge ACLK);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_zero_wait_timing();
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n_checks++; if ({AWVALID, WVALID, BREADY, AWADDR, WDATA, WSTRB} !== {3'b110, 32'h0C, 32'h0BADF00D, 4'hF}) begin
            n_fail++; $display("FAIL wr_cycle1: AWV/WV/BR=%b AWADDR=%h WDATA=%h WSTRB=%h want 110/0c/0badf00d/f", {AWVALID, WVALID, BREADY}, AWADDR, WDATA, WSTRB); end
        @(negedge ACLK);
        n_checks++; if ({AWVALID, WVALID, BREADY, BVALID, rsp_valid} !== 5'b00110) begin
            n_fail++; $display("FAIL wr_cycle2: got %b want 00110", {AWVALID, WVALID, BREADY, BVALID, rsp_valid}); end
        @(negedge ACLK);
        n_checks++; if ({BREADY, rsp_valid, rsp_resp, rsp_rdata} !== {4'b0100, 32'h0}) begin
            n_fail++; $display("FAIL wr_cycle3: BR/rv/resp=%b rdata=%h want 0100/0", {BREADY, rsp_valid, rsp_resp}, rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL wr_return_idle: rv/cr=%b want 01", {rsp_valid, cmd_ready}); end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0C;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n_checks++; if ({ARVALID, ARREADY, RREADY, ARADDR} !== {3'b110, 32'h0C}) begin
            n_fail++; $display("FAIL rd_cycle1: ARV/ARR/RR=%b ARADDR=%h want 110/0c", {ARVALID, ARREADY, RREADY}, ARADDR); end
        @(negedge ACLK);
        n_checks++; if ({ARVALID, RREADY, RVALID, rsp_valid} !== 4'b0110) begin
            n_fail++; $display("FAIL rd_cycle2: got %b want 0110", {ARVALID, RREADY, RVALID, rsp_valid}); end
        @(negedge ACLK);
        n_checks++; if ({RREADY, rsp_valid, rsp_resp, rsp_rdata} !== {4'b0100, 32'h0BADF00D}) begin
            n_fail++; $display("FAIL rd_cycle3: RR/rv/resp=%b rdata=%h want 0100/0badf00d", {RREADY, rsp_valid, rsp_resp}, rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_read();
        bit ok1, ok2, ok3, ok4; logic [31:0] rd; logic [1:0] rr; logic to;
        send_cmd(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr, to, rd} !== {5'b11000, 32'h0}) begin
            n_fail++; $display("FAIL wr04: ok=%b%b resp=%b to=%b rdata=%h want 11/00/0/0", ok1, ok2, rr, to, rd); end
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0, ok3); get_rsp(ok4, rd, rr, to);
        n_checks++; if ({ok3, ok4, rr, to, rd} !== {5'b11000, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rd04: ok=%b%b resp=%b to=%b rdata=%h want 11/00/0/deadbeef", ok3, ok4, rr, to, rd); end
    endtask

    task automatic test_strobe();
        bit ok1, ok2; logic [31:0] rd; logic [1:0] rr; logic to;
        send_cmd(1'b1, 32'h08, 32'h11223344, 4'hF, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr} !== 4'b1100) begin n_fail++; $display("FAIL wr08_full: ok=%b%b resp=%b want 11/00", ok1, ok2, rr); end
        send_cmd(1'b1, 32'h08, 32'h000000AA, 4'h1, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr} !== 4'b1100) begin n_fail++; $display("FAIL wr08_strb: ok=%b%b resp=%b want 11/00", ok1, ok2, rr); end
        send_cmd(1'b0, 32'h08, 32'h0, 4'h0, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr, rd} !== {4'b1100, 32'h112233AA}) begin
            n_fail++; $display("FAIL rd08_strb: ok=%b%b resp=%b rdata=%h want 11/00/112233aa", ok1, ok2, rr, rd); end
    endtask

    task automatic test_out_of_range();
        bit ok1, ok2; logic [31:0] rd; logic [1:0] rr; logic to;
        send_cmd(1'b0, 32'h40, 32'h0, 4'h0, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr, rd} !== {4'b1110, 32'h0}) begin
            n_fail++; $display("FAIL rd40_slverr: ok=%b%b resp=%b rdata=%h want 11/10/0", ok1, ok2, rr, rd); end
        send_cmd(1'b1, 32'h40, 32'hCAFECAFE, 4'hF, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr, rd} !== {4'b1110, 32'h0}) begin
            n_fail++; $display("FAIL wr40_slverr: ok=%b%b resp=%b rdata=%h want 11/10/0", ok1, ok2, rr, rd); end
    endtask

    task automatic test_aw_stall();
        bit ok1, ok2; logic [31:0] rd; logic [1:0] rr; logic to;
        int cyc, aw_n, w_n, b_first; bit addr_bad;
        aw_wait = 3;
        send_cmd(1'b1, 32'h10, 32'h55AA55AA, 4'hF, ok1);
        cyc = 1; aw_n = 0; w_n = 0; b_first = 0; addr_bad = 1'b0;
        while (!rsp_valid && cyc < 30) begin
            if (AWVALID) begin aw_n++; if (AWADDR !== 32'h10) addr_bad = 1'b1; end
            if (WVALID) w_n++;
            if (BREADY && b_first == 0) b_first = cyc;
            @(negedge ACLK); cyc++;
        end
        get_rsp(ok2, rd, rr, to);
        aw_wait = 0;
        n_checks++; if (aw_n !== 4) begin n_fail++; $display("FAIL aw_stall_awvalid_len: got %0d want 4", aw_n); end
        n_checks++; if (w_n !== 1) begin n_fail++; $display("FAIL aw_stall_wvalid_len: got %0d want 1", w_n); end
        n_checks++; if (b_first !== 5) begin n_fail++; $display("FAIL aw_stall_bready_cycle: got %0d want 5", b_first); end
        n_checks++; if ({addr_bad, ok1, ok2, rr} !== 5'b01100) begin
            n_fail++; $display("FAIL aw_stall_rsp: addr_bad=%b ok=%b%b resp=%b want 0/11/00", addr_bad, ok1, ok2, rr); end
    endtask

    task automatic test_rsp_backpressure();
        bit ok1, ok2, seen, unstable, early_ready; logic [31:0] rd, snap_d; logic [1:0] rr, snap_r; logic to;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, ok1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            @(negedge ACLK);
        end
        snap_d = rsp_rdata; snap_r = rsp_resp;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'h01020304; cmd_wstrb = 4'hF;
        unstable = 1'b0; early_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || rsp_rdata !== snap_d || rsp_resp !== snap_r) unstable = 1'b1;
            if (cmd_ready !== 1'b0) early_ready = 1'b1;
            @(negedge ACLK);
        end
        n_checks++; if ({ok1, seen, snap_r, snap_d} !== {4'b1100, 32'h55AA55AA}) begin
            n_fail++; $display("FAIL bp_rsp_value: ok=%b seen=%b resp=%b rdata=%h want 1/1/00/55aa55aa", ok1, seen, snap_r, snap_d); end
        n_checks++; if ({unstable, early_ready} !== 2'b00) begin
            n_fail++; $display("FAIL bp_hold: unstable=%b cmd_ready_seen=%b want 0/0", unstable, early_ready); end
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        n_checks++; if ({rsp_valid, cmd_ready, AWVALID} !== 3'b010) begin
            n_fail++; $display("FAIL bp_idle_gap: rv/cr/awv=%b want 010", {rsp_valid, cmd_ready, AWVALID}); end
        @(negedge ACLK);
        cmd_valid = 1'b0;
        n_checks++; if ({AWVALID, cmd_ready} !== 2'b10) begin
            n_fail++; $display("FAIL bp_next_accept: awv/cr=%b want 10", {AWVALID, cmd_ready}); end
        get_rsp(ok2, rd, rr, to);
        send_cmd(1'b0, 32'h14, 32'h0, 4'h0, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr, rd} !== {4'b1100, 32'h01020304}) begin
            n_fail++; $display("FAIL bp_next_data: ok=%b%b resp=%b rdata=%h want 11/00/01020304", ok1, ok2, rr, rd); end
    endtask

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok1, ok2; logic [31:0] rd; logic [1:0] rr; logic to; int cyc, ar_n;
        ar_stuck = 1'b1;
        send_cmd(1'b0, 32'h08, 32'h0, 4'h0, ok1);
        cyc = 1; ar_n = 0;
        while (!rsp_valid && cyc < 60) begin
            if (ARVALID) ar_n++;
            @(negedge ACLK); cyc++;
        end
        get_rsp(ok2, rd, rr, to);
        ar_stuck = 1'b0;
        n_checks++; if (ar_n !== 16) begin n_fail++; $display("FAIL tmo_arvalid_len: got %0d want 16", ar_n); end
        n_checks++; if ({ok1, ok2, rr, to, rd} !== {5'b11101, 32'h0}) begin
            n_fail++; $display("FAIL tmo_rsp: ok=%b%b resp=%b to=%b rdata=%h want 11/10/1/0", ok1, ok2, rr, to, rd); end
        send_cmd(1'b0, 32'h08, 32'h0, 4'h0, ok1); get_rsp(ok2, rd, rr, to);
        n_checks++; if ({ok1, ok2, rr, to, rd} !== {5'b11000, 32'h112233AA}) begin
            n_fail++; $display("FAIL tmo_recover: ok=%b%b resp=%b to=%b rdata=%h want 11/00/0/112233aa", ok1, ok2, rr, to, rd); end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok1, in_rd, saw_rsp;
        r_hold = 1'b1;
        send_cmd(1'b0, 32'h04, 32'h0, 4'h0, ok1);
        in_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (RREADY) begin in_rd = 1'b1; break; end
            @(negedge ACLK);
        end
        n_checks++; if ({ok1, in_rd, ARADDR} !== {2'b11, 32'h04}) begin
            n_fail++; $display("FAIL rstmid_reach_rd_data: ok=%b rready=%b ARADDR=%h want 1/1/04", ok1, in_rd, ARADDR); end
        ARESET = 1'b1;
        @(negedge ACLK);
        n_checks++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, cmd_ready} !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b want 00000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, cmd_ready}); end
        n_checks++; if ({AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp} !== 134'h0) begin
            n_fail++; $display("FAIL rstmid_payload: AWADDR=%h ARADDR=%h WDATA=%h rdata=%h resp=%b want all 0", AWADDR, ARADDR, WDATA, rsp_rdata, rsp_resp); end
        ARESET = 1'b0; r_hold = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        n_checks++; if ({saw_rsp, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_no_rsp: rsp_seen=%b cmd_ready=%b want 0/1", saw_rsp, cmd_ready); end
    endtask

    initial begin
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; aw_wait = 0; w_wait = 0; ar_wait = 0; ar_stuck = 1'b0; r_hold = 1'b0;
        test_reset();
        test_zero_wait_timing();
        test_write_read();
        test_strobe();
        test_out_of_range();
        test_aw_stall();
        test_rsp_backpressure();
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
